stream_fork_using_fifos: RTL
============================

Name: stream_fork_using_fifos

Overview:
- Splits one valid/ready input stream into two identical output streams, x and y. This is the fork counterpart of the two-stream join/adder.
- Each output has its own counter-based FIFO, so a consumer stalled on one branch is absorbed up to depth entries before it back-pressures the producer.
- Sits between a single producer and two independent consumers in the stream pipeline.

Parameters:
- width, 8, data width of every stream
- depth, 10, entries per branch FIFO; any value ≥ 2, not necessarily a power of two

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- up_valid  input  1  producer has data
- up_ready  output  1  block accepts data this cycle
- up_data  input  width  producer data
- x_valid  output  1  branch x has data
- x_ready  input  1  consumer x accepts
- x_data  output  width  branch x data
- y_valid  output  1  branch y has data
- y_ready  input  1  consumer y accepts
- y_data  output  width  branch y data
- x_count  output  $clog2(depth+1)  current x FIFO occupancy
- y_count  output  $clog2(depth+1)  current y FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and counters go to 0.
  - x_valid = y_valid = 0, x_count = y_count = 0, up_ready = 1.
  - Storage contents are not reset; x_data and y_data are don't-care while valid is 0.
- Reset asserted mid-transfer discards all queued data. No partial state survives.
- Each branch FIFO:
  - wr_ptr, rd_ptr in 0..depth-1; wrap from depth-1 to 0 explicitly (no power-of-two reliance).
  - count in 0..depth.
  - full = (count == depth); empty = (count == 0).
- Lockstep fork:
  - up_ready = ~x_full & ~y_full. It depends only on registered state, never on x_ready or y_ready.
  - push = up_valid & up_ready writes up_data into both FIFOs in the same cycle.
- Outputs:
  - x_valid = ~x_empty; x_data = x_mem[x_rd_ptr]; pop_x = x_valid & x_ready. Branch y is identical.
- Latency: a word accepted at edge N is visible on x and y after edge N (1 cycle) when the FIFO was empty.
- Simultaneous push and pop on one FIFO: count unchanged, both pointers advance.
- A pop on a full FIFO does not raise up_ready in the same cycle. It rises the next cycle; no same-cycle pass-through of space.
- Branches drain independently:
  - x_count and y_count may differ by up to depth.
  - Ordering within each branch is strictly FIFO.
  - Every accepted word appears exactly once on x and exactly once on y.
- A pop when empty, or a push when full, cannot occur by construction. Assertions check both.
- x_count and y_count are registered outputs.

Optional Feature:
- Macro: STREAM_FORK_BYPASS_EN
- Defined:
  - When a branch FIFO is empty, up_valid & up_ready, and that branch's ready is 1, the word passes combinationally to that branch's output in the same cycle (0-cycle latency) and is not written to that FIFO.
  - The other branch behaves normally: it either bypasses too or is written.
  - x_valid = ~x_empty | (x_empty & up_valid & up_ready); x_data muxes up_data when empty. Same for y.
  - up_ready is unchanged (still full-based, so no combinational ready→ready path).
- Undefined: no bypass; minimum latency 1 cycle as specified above.

Test Plan:
- Reset, then idle -> up_ready=1, x_valid=y_valid=0, counts 0.
- Push 0x11,0x22,0x33 back-to-back, x_ready=y_ready=1 -> both branches output 0x11,0x22,0x33 in order, each one cycle after acceptance (0 cycles with STREAM_FORK_BYPASS_EN).
- Hold y_ready=0, x_ready=1, push 12 words 0x00..0x0B with up_valid=1 -> up_ready falls after 10 accepts, y_count=10, x drains all 10. Release y_ready -> y outputs 0x00..0x09, then 0x0A and 0x0B are accepted.
- Both FIFOs full, x_ready=y_ready=1, up_valid=1 -> up_ready 0 that cycle, 1 next cycle; counts hold at depth-1 to depth thereafter, no loss.
- Push 25 words with random x_ready/y_ready -> x and y each see the same 25-word sequence, exercising pointer wrap at index 9→0 at least twice.
- Assert rst_n low mid-stream with 5 words queued -> all outputs return to reset values immediately, without waiting for a clock edge; after release no old data appears.

Source files
------------

// File: rtl/stream_fork_using_fifos.sv
// rtl/stream_fork_using_fifos.sv - one-to-two stream fork with a counter-based FIFO per branch; optional STREAM_FORK_BYPASS_EN
// One branch FIFO: explicit pointer wrap so any depth >= 2 works.
module stream_fork_fifo #(
    parameter int width = 8,
    parameter int depth = 10,
    parameter int CW    = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [width-1:0] i_data,
    input  logic             i_rd,
    output logic [width-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CW'(depth));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is deliberately left out of reset; valid gates the data.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; push+pop together advances both and holds count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (i_rd) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({i_wr, i_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_wr && o_full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_rd && o_empty));
endmodule

// Fork top: producer is accepted only when both branches have room.
module stream_fork_using_fifos #(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [width-1:0]           up_data,
    output logic                       x_valid,
    input  logic                       x_ready,
    output logic [width-1:0]           x_data,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [width-1:0]           y_data,
    output logic [$clog2(depth+1)-1:0] x_count,
    output logic [$clog2(depth+1)-1:0] y_count
);
    localparam int CW = $clog2(depth + 1);

    logic             w_push;
    logic             w_x_wr, w_x_rd, w_x_full, w_x_empty;
    logic             w_y_wr, w_y_rd, w_y_full, w_y_empty;
    logic [width-1:0] w_x_fifo_data, w_y_fifo_data;

    // Ready comes only from registered occupancy, never from downstream ready.
    assign up_ready = ~w_x_full & ~w_y_full;
    assign w_push   = up_valid & up_ready;

`ifdef STREAM_FORK_BYPASS_EN
    logic w_x_byp, w_y_byp;

    // An empty branch whose consumer is ready takes the word directly.
    assign w_x_byp = w_x_empty & w_push & x_ready;
    assign w_y_byp = w_y_empty & w_push & y_ready;
    assign w_x_wr  = w_push & ~w_x_byp;
    assign w_y_wr  = w_push & ~w_y_byp;
    assign x_valid = ~w_x_empty | (w_x_empty & w_push);
    assign y_valid = ~w_y_empty | (w_y_empty & w_push);
    assign x_data  = w_x_empty ? up_data : w_x_fifo_data;
    assign y_data  = w_y_empty ? up_data : w_y_fifo_data;
    assign w_x_rd  = ~w_x_empty & x_ready;
    assign w_y_rd  = ~w_y_empty & y_ready;
`else
    assign w_x_wr  = w_push;
    assign w_y_wr  = w_push;
    assign x_valid = ~w_x_empty;
    assign y_valid = ~w_y_empty;
    assign x_data  = w_x_fifo_data;
    assign y_data  = w_y_fifo_data;
    assign w_x_rd  = x_valid & x_ready;
    assign w_y_rd  = y_valid & y_ready;
`endif

    stream_fork_fifo #(.width(width), .depth(depth), .CW(CW)) u_x_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_x_wr),
        .i_data  (up_data),
        .i_rd    (w_x_rd),
        .o_data  (w_x_fifo_data),
        .o_count (x_count),
        .o_full  (w_x_full),
        .o_empty (w_x_empty)
    );

    stream_fork_fifo #(.width(width), .depth(depth), .CW(CW)) u_y_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_y_wr),
        .i_data  (up_data),
        .i_rd    (w_y_rd),
        .o_data  (w_y_fifo_data),
        .o_count (y_count),
        .o_full  (w_y_full),
        .o_empty (w_y_empty)
    );
endmodule
